// File: rtl/ppu_stream.sv
// Streaming pixel generator: an input FIFO feeding a one-deep output register,
// with an IDLE/ACTIVE frame sequencer producing test patterns or passthrough pixels.
module ppu_stream #(
  parameter int H_PIXELS   = 32,
  parameter int V_LINES    = 32,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sync,
  input  logic [2:0]                    mode,
  input  logic [PIX_W-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [PIX_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(H_PIXELS);
  localparam int VW = $clog2(V_LINES);
  localparam logic [HW-1:0] H_LAST = HW'(H_PIXELS - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_LINES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [PIX_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [HW-1:0]           h_cnt;
  logic [VW-1:0]           v_cnt;
  logic [PIX_W-1:0]        pix_p0;
  logic                    vld_p0;
  logic                    fifo_has;
  logic                    pix_avail;
  logic                    load;
  logic                    push;
  logic                    pop;
  logic [PIX_W-1:0]        next_pix;

  // Pattern generator; h/v/frame are pre-sized to PIX_W so XOR and the mode-2 sum wrap naturally.
  function automatic logic [PIX_W-1:0] gen_pixel(
    input logic [2:0]       m,
    input logic [PIX_W-1:0] hx,
    input logic [PIX_W-1:0] vx,
    input logic [PIX_W-1:0] fx,
    input logic [PIX_W-1:0] head,
    input logic             have_head
  );
    logic [PIX_W-1:0] pix;
    case (m)
      3'd0:    pix = head;
      3'd1:    pix = hx ^ vx;
      3'd2:    pix = (vx + fx) ^ hx;
      3'd3:    pix = {PIX_W{hx[3] ^ vx[3]}};
      3'd4:    pix = have_head ? head : (hx ^ vx);
      default: pix = '0;
    endcase
    return pix;
  endfunction

  assign in_ready  = (fifo_level != LVL_FULL);
  assign fifo_has  = (fifo_level != '0);
  assign push      = in_valid && in_ready;
  assign pix_avail = (mode != 3'd0) || fifo_has;
  assign load      = (!vld_p0 || out_ready) && (state == ACTIVE) && pix_avail;
  assign pop       = load && ((mode == 3'd0) || (mode == 3'd4)) && fifo_has;
  assign next_pix  = gen_pixel(mode, PIX_W'(h_cnt), PIX_W'(v_cnt), PIX_W'(frame_count),
                               mem[rd_ptr], fifo_has);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sequencer: sync restarts the raster but never bumps the frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync) state <= ACTIVE;
        end
        ACTIVE: begin
          if (sync) begin
            h_cnt <= '0;
            v_cnt <= '0;
          end else if (load) begin
            if (h_cnt == H_LAST) begin
              h_cnt <= '0;
              if (v_cnt == V_LAST) begin
                v_cnt       <= '0;
                frame_count <= frame_count + 8'd1;
              end else begin
                v_cnt <= v_cnt + 1'b1;
              end
            end else begin
              h_cnt <= h_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: output register; an accepted beat with nothing new behind it clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      pix_p0 <= '0;
    end else if (load) begin
      vld_p0 <= 1'b1;
      pix_p0 <= next_pix;
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_data  = pix_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_ppu_stream.sv
// Scoreboard bench for ppu_stream: stimulus pushes expected pixels, a monitor
// pops and compares on every accepted output beat.
module tb_ppu_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] fifo_level;
  logic [7:0] frame_count;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         acc_cnt = 0;

  ppu_stream #(.H_PIXELS(32), .V_LINES(32), .PIX_W(8), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .sync(sync), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst = 1'b1; sync = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(name, acc_cnt, target);
  endtask

  // Monitor: compare each accepted beat against the scoreboard head.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("out_data", int'(out_data), int'(exp_v));
        end
      end
    end
  end

  initial begin
    int acc0;
    int wr;
    logic [7:0] v8;

    // Reset state
    tick();
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_count", frame_count, 0);

    // Mode 1 raster: latency and first two lines
    mode = 3'd1; out_ready = 1'b1;
    for (int h = 0; h < 32; h++) exp_q.push_back(8'(h));
    for (int h = 0; h < 32; h++) exp_q.push_back(8'(h ^ 1));
    sync_pulse();
    check("m1_valid_lat1", out_valid, 0);
    tick();
    check("m1_valid_lat2", out_valid, 1);
    wait_drain("m1_drain", 100);

    // Mode 0 passthrough of two words, then h must sit at 2
    do_reset();
    mode = 3'd0; out_ready = 1'b1;
    sync_pulse();
    in_valid = 1'b1; in_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    in_data = 8'h3C; exp_q.push_back(8'h3C);
    tick();
    in_valid = 1'b0;
    wait_drain("m0_drain", 20);
    tick(); tick();
    check("m0_valid_empty", out_valid, 0);
    check("m0_level_empty", fifo_level, 0);
    exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    mode = 3'd1;
    wait_drain("m0_h_adv", 20);

    // FIFO fill to full in IDLE, 33rd word refused
    do_reset();
    mode = 3'd0; out_ready = 1'b0; wr = 0;
    for (int i = 0; i < 33; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      @(negedge clk);
      if (in_ready) wr++;
      tick();
    end
    in_valid = 1'b0;
    check("full_writes", wr, 32);
    check("full_level", fifo_level, 32);
    check("full_in_ready", in_ready, 0);
    sync_pulse();
    tick();
    check("full_pop_valid", out_valid, 1);
    check("full_pop_data", out_data, 0);
    check("full_pop_level", fifo_level, 31);
    check("full_pop_in_ready", in_ready, 1);
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(i));
    acc0 = acc_cnt;
    out_ready = 1'b1;
    wait_drain("full_drain", 100);
    tick(); tick();
    check("full_accepts", acc_cnt - acc0, 32);
    check("full_end_level", fifo_level, 0);
    check("full_end_valid", out_valid, 0);

    // Mode 1 stall mid-line
    do_reset();
    mode = 3'd1; out_ready = 1'b1;
    for (int h = 0; h < 32; h++) exp_q.push_back(8'(h));
    for (int h = 0; h < 32; h++) exp_q.push_back(8'(h ^ 1));
    acc0 = acc_cnt;
    sync_pulse();
    wait_acc("stall_reach", acc0 + 10, 100);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_data", out_data, int'(exp_q[0]));
      check("stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("stall_drain", 100);

    // Mode 2 two full frames, then reset with a pending beat and 7 queued words
    do_reset();
    mode = 3'd2; out_ready = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int v = 0; v < 32; v++)
        for (int h = 0; h < 32; h++) begin
          v8 = 8'(v + f);
          exp_q.push_back(v8 ^ 8'(h));
        end
    exp_q.push_back(8'h02);
    sync_pulse();
    wait_drain("m2_drain", 2200);
    check("m2_frame_count", frame_count, 2);
    out_ready = 1'b0; mode = 3'd0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("prerst_level", fifo_level, 7);
    check("prerst_valid", out_valid, 1);
    do_reset();
    check("postrst_valid", out_valid, 0);
    check("postrst_level", fifo_level, 0);
    check("postrst_frame", frame_count, 0);
    check("postrst_in_ready", in_ready, 1);

    // Mode 2 sync at h=17 while stalled: pending pixel kept, raster restarts
    mode = 3'd2; out_ready = 1'b1;
    for (int h = 0; h < 17; h++) exp_q.push_back(8'(h));
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    acc0 = acc_cnt;
    sync_pulse();
    wait_acc("sync17_reach", acc0 + 16, 100);
    out_ready = 1'b0;
    sync_pulse();
    check("sync17_pending", out_data, 16);
    check("sync17_frame", frame_count, 0);
    tick();
    out_ready = 1'b1;
    wait_drain("sync17_drain", 50);

    // Mode 4: FIFO words first, then h^v fallback
    do_reset();
    mode = 3'd4;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    for (int h = 2; h < 6; h++) exp_q.push_back(8'(h));
    out_ready = 1'b1;
    sync_pulse();
    wait_drain("m4_drain", 50);
    check("m4_level", fifo_level, 0);

    // Mode 3 checkerboard across line 0 and start of line 1
    do_reset();
    mode = 3'd3; out_ready = 1'b1;
    for (int h = 0; h < 32; h++) exp_q.push_back(((h >> 3) & 1) != 0 ? 8'hFF : 8'h00);
    for (int h = 0; h < 8; h++) exp_q.push_back(8'h00);
    sync_pulse();
    wait_drain("m3_drain", 100);

    // Mode 5: zeros, FIFO left untouched
    do_reset();
    mode = 3'd0;
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_data = 8'h88; tick();
    in_valid = 1'b0;
    mode = 3'd5; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
    sync_pulse();
    wait_drain("m5_drain", 50);
    check("m5_level", fifo_level, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
